// File: rtl/cmd_pkg.sv
// Shared constants and types for the command packet receive path.
package cmd_pkg;

  localparam int DEF_WORD_WIDTH  = 8;
  localparam int DEF_VALUE_WORDS = 4;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'haa;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } asm_state_t;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter; o_expired flags the last idle cycle a partial packet may survive.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SAT  = '1;

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_run && (count_q != SAT)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == LAST);

endmodule

// File: rtl/packet_assembler.sv
// Collects a command word, an address word and VALUE_WORDS value words into one
// registered packet; partial packets are dropped after an idle timeout.
module packet_assembler
  import cmd_pkg::*;
#(
  parameter int  WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int  VALUE_WORDS    = DEF_VALUE_WORDS,
  parameter int  TIMEOUT_CYCLES = 100000,
  localparam int PKT_WORDS      = VALUE_WORDS + 2
) (
  input  logic                            clk,
  input  logic                            i_reset_n,
  input  logic [WORD_WIDTH-1:0]           i_word,
  input  logic                            i_word_valid,
  output logic [PKT_WORDS*WORD_WIDTH-1:0] o_data,
  output logic                            o_dv,
  output logic                            o_busy,
  output logic                            o_timeout
);

  localparam int PW = PKT_WORDS * WORD_WIDTH;
  localparam int SW = PW - WORD_WIDTH;
  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

  asm_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [PW-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          armed_q;
  logic          strobe, expired, last_word;
  logic [PW-1:0] shifted;

  // armed_q masks a strobe that lands on the first edge after reset release.
  assign strobe    = i_word_valid & armed_q;
  assign last_word = (count_q == LAST_IDX);
  assign shifted   = {shift_q, i_word};

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .i_clear  (strobe | (state_q != ST_COLLECT)),
    .i_run    (state_q == ST_COLLECT),
    .o_expired(expired)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      armed_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (strobe) begin
          if (last_word) state_d = ST_DONE;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = strobe ? ST_COLLECT : ST_IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    timeout_d = 1'b0;
    busy_d    = (state_d == ST_COLLECT);
    unique case (state_q)
      ST_COLLECT: begin
        if (strobe) begin
          count_d = count_q + CW'(1);
          shift_d = shifted[SW-1:0];
          if (last_word) begin
            data_d = shifted;
            dv_d   = 1'b1;
          end
        end else if (expired) begin
          count_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        // A word in IDLE or DONE always opens a fresh packet.
        if (strobe) begin
          count_d = CW'(1);
          shift_d = SW'(i_word);
        end else begin
          count_d = '0;
        end
      end
    endcase
  end

  assign o_data    = data_q;
  assign o_dv      = dv_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, giving the bits per received word.
REQ-002 SHALL have parameter VALUE_WORDS, default 4, giving the value words per packet; the packet length is PKT_WORDS = VALUE_WORDS+2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the idle clocks allowed between words of one packet; the legal minimum is 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_word, input, WORD_WIDTH bits: a received word from the serial receiver.
REQ-007 SHALL have port i_word_valid, input, 1 bit: a one-cycle strobe qualifying i_word.
REQ-008 SHALL have port o_data, output, PKT_WORDS*WORD_WIDTH bits: the assembled packet, in command/address/value order, MSB first.
REQ-009 SHALL have port o_dv, output, 1 bit: a one-cycle pulse meaning o_data holds a new complete packet.
REQ-010 SHALL have port o_busy, output, 1 bit: a partial packet is in progress.
REQ-011 SHALL have port o_timeout, output, 1 bit: a one-cycle pulse meaning a partial packet was discarded.

Function
REQ-012 SHALL implement the states IDLE, COLLECT and DONE.
REQ-013 SHALL, in IDLE with i_word_valid=1: store the word as the command word, set word count to 1, go to COLLECT.
REQ-014 SHALL, in COLLECT with i_word_valid=1: shift the word into the next lower slot, increment the count, and clear the idle timer.
REQ-015 SHALL go to DONE on the cycle the count reaches PKT_WORDS.
REQ-016 SHALL fill o_data in arrival order: the first word goes to bits [PKT_WORDS*WORD_WIDTH-1 -: WORD_WIDTH], the last word to bits [WORD_WIDTH-1:0].
REQ-017 SHALL, in DONE, assert o_dv for exactly one cycle, which is the cycle after the last word strobe, then return to IDLE.
REQ-018 SHALL update o_data only when DONE is entered, and hold it stable from then until the next DONE; a partial packet is never visible on o_data.
REQ-019 SHALL accept a word arriving while in DONE as the first word of the next packet: go to COLLECT with count 1; o_dv still pulses.
REQ-020 SHALL hold o_dv low for at least one cycle between two pulses, so that a downstream rising-edge detector sees every packet.
REQ-021 SHALL increment the idle timer on every COLLECT cycle that has no strobe; the timer is $clog2(TIMEOUT_CYCLES) bits and saturates, never wrapping.
REQ-022 SHALL, when the timer equals TIMEOUT_CYCLES-1 and no strobe is present: discard the partial packet, pulse o_timeout for one cycle, go to IDLE; o_data is unchanged.
REQ-023 SHALL give a strobe priority over a timeout on the same cycle: the word is accepted and no timeout occurs.
REQ-024 SHALL drive o_busy high exactly when the state is COLLECT.
REQ-025 SHALL ignore word content: command decoding belongs downstream, and an unknown command word is still assembled and delivered.
REQ-026 SHALL accept back-to-back strobes on consecutive cycles with no loss.

Reset
REQ-027 SHALL, while i_reset_n=0, immediately force the state to IDLE, count 0, timer 0, o_data 0, o_dv 0, o_timeout 0, and o_busy 0.
REQ-028 SHALL, on reset asserted mid-packet, discard the partial packet; no o_dv or o_timeout pulse is produced, either at assertion or at release.
REQ-029 SHALL ignore a strobe coincident with the first clock edge after reset release.

Structure
REQ-030 SHALL take the following from shared package cmd_pkg: WORD_WIDTH and VALUE_WORDS defaults, the CMD_READ (0x00) and CMD_WRITE (0xaa) constants, and the assembler state enum typedef.
REQ-031 SHALL place the idle timer in sub-module idle_timer, with ports clk, i_reset_n, i_clear, i_run, o_expired and parameter TIMEOUT_CYCLES.
REQ-032 SHALL register all outputs, with no combinational path from any input to any output.

Verification
REQ-033 SHALL test a single packet: strobe aa,05,de,ad,be,ef, each 10 cycles apart -> one o_dv pulse one cycle after the ef strobe, with o_data=0xaa05deadbeef.
REQ-034 SHALL test back-to-back packets: 12 strobes on consecutive cycles, 00,01,11,22,33,44 then aa,02,01,02,03,04 -> two o_dv pulses 6 cycles apart, o_data=0x000111223344 then 0xaa0201020304, and o_dv low between the pulses.
REQ-035 SHALL test timeout: with TIMEOUT_CYCLES=16, strobe aa,07,01 then silence -> o_timeout pulses 16 cycles after the 01 strobe, o_busy falls, o_data keeps its previous value, no o_dv.
REQ-036 SHALL test the strobe/timeout race: with TIMEOUT_CYCLES=16, a strobe on the expiry cycle -> no o_timeout, the count advances, and a packet completes normally.
REQ-037 SHALL test reset mid-packet: assert i_reset_n=0 asynchronously after 3 words -> all outputs are 0 immediately; after release, a full 6-word packet is delivered correctly.
REQ-038 SHALL test a strobe in DONE: a 7th strobe the cycle after the 6th -> o_dv pulses once and o_busy=1 with count 1, and the next 5 words complete the second packet.
